up_bus_master: RTL and testbench

//  Initiator for the up_wr_*/up_rd_* register bus. Converts single-beat commands from a
//  cmd valid/ready stream (host/MQTT command path) into bus write/read transactions.

---
 rtl/up_bus_master.sv | 208 ++++++++++++++++++++
 tb/tb_up_bus_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_bus_master.sv
// Single-outstanding initiator for the up_wr_*/up_rd_* register bus, fed by a cmd/rsp valid-ready pair.
// Optional WAIT-state abort is compiled in with `define UP_MASTER_TIMEOUT_EN.
module up_bus_master #(
  parameter int C_ADDR_WIDTH = 8,
  parameter int C_TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [C_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]             cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [C_ADDR_WIDTH-1:0] up_wr_addr,
  output logic                    up_wr_req,
  output logic [31:0]             up_wr_din,
  input  logic                    up_wr_ack,
  output logic [C_ADDR_WIDTH-1:0] up_rd_addr,
  output logic                    up_rd_req,
  input  logic [31:0]             up_rd_dout,
  input  logic                    up_rd_ack,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  if (C_TIMEOUT < 2) begin : gTimeoutCheck
    $error("up_bus_master: C_TIMEOUT must be at least 2");
  end

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    busy_q, busy_d;
  logic                    is_wr_q, is_wr_d;
  logic                    wr_req_q, wr_req_d;
  logic                    rd_req_q, rd_req_d;
  logic [C_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [C_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]             wr_din_q, wr_din_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    ack_hit;
  logic                    expired;

  // Only the acknowledge matching the latched direction may complete a transaction.
  assign ack_hit = is_wr_q ? up_wr_ack : up_rd_ack;

`ifdef UP_MASTER_TIMEOUT_EN
  function automatic int calcCntWidth(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8)  w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

  localparam int CNT_W = calcCntWidth(C_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;

  assign expired = (cnt_q == CNT_W'(C_TIMEOUT - 1));
  assign rsp_err = rsp_err_q;
`else
  assign expired = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      is_wr_q     <= 1'b0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_din_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef UP_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      is_wr_q     <= is_wr_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_din_q    <= wr_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef UP_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Next values are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    is_wr_d     = is_wr_q;
    wr_req_d    = 1'b0;
    rd_req_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    wr_din_d    = wr_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef UP_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_REQ;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          is_wr_d     = cmd_wr;
          if (cmd_wr) begin
            wr_req_d  = 1'b1;
            wr_addr_d = cmd_addr;
            wr_din_d  = cmd_wdata;
          end else begin
            rd_req_d  = 1'b1;
            rd_addr_d = cmd_addr;
          end
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
`ifdef UP_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      // A genuine ack takes priority over expiry in the same cycle.
      ST_WAIT: begin
        if (ack_hit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = is_wr_q ? 32'h0 : up_rd_dout;
`ifdef UP_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end else if (expired) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'hDEADBEEF;
`ifdef UP_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b1;
`endif
        end else begin
`ifdef UP_MASTER_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign up_wr_req  = wr_req_q;
  assign up_rd_req  = rd_req_q;
  assign up_wr_addr = wr_addr_q;
  assign up_rd_addr = rd_addr_q;
  assign up_wr_din  = wr_din_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_up_bus_master.sv
// Directed bench for up_bus_master: writes, reads, backpressure, stray acks, timeout and mid-transaction reset.
module tb_up_bus_master;

  localparam int AW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] up_wr_addr;
  logic          up_wr_req;
  logic [31:0]   up_wr_din;
  logic          up_wr_ack;
  logic [AW-1:0] up_rd_addr;
  logic          up_rd_req;
  logic [31:0]   up_rd_dout;
  logic          up_rd_ack;
  logic          busy;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  up_bus_master #(
    .C_ADDR_WIDTH(AW),
    .C_TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .up_wr_addr(up_wr_addr),
    .up_wr_req (up_wr_req),
    .up_wr_din (up_wr_din),
    .up_wr_ack (up_wr_ack),
    .up_rd_addr(up_rd_addr),
    .up_rd_req (up_rd_req),
    .up_rd_dout(up_rd_dout),
    .up_rd_ack (up_rd_ack),
    .busy      (busy)
  );

  // Presents a command for one edge; returns at the negedge of the REQ cycle.
  task automatic issueCmd(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_valid, rsp_err, up_wr_req, up_rd_req} !== 6'b100000)
      $display("[TB] FAIL reset_ctrl: got %b expected 100000",
               {cmd_ready, busy, rsp_valid, rsp_err, up_wr_req, up_rd_req});
    else passes++;
    checks++;
    if ({rsp_rdata, up_wr_din, up_wr_addr, up_rd_addr} !== '0)
      $display("[TB] FAIL reset_data: got %h expected 0",
               {rsp_rdata, up_wr_din, up_wr_addr, up_rd_addr});
    else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    rsp_ready = 1'b1;
    issueCmd(1'b1, 8'h04, 32'h12345678);
    checks++;
    if ({up_wr_req, up_rd_req, cmd_ready, busy} !== 4'b1001)
      $display("[TB] FAIL wr_req_cycle: got %b expected 1001", {up_wr_req, up_rd_req, cmd_ready, busy});
    else passes++;
    checks++;
    if (up_wr_addr !== 8'h04 || up_wr_din !== 32'h12345678)
      $display("[TB] FAIL wr_addr_din: got %h/%h expected 04/12345678", up_wr_addr, up_wr_din);
    else passes++;
    @(negedge clk);
    checks++;
    if (up_wr_req !== 1'b0 || rsp_valid !== 1'b0 || up_wr_din !== 32'h12345678)
      $display("[TB] FAIL wr_wait: got req=%b rsp_valid=%b din=%h expected 0/0/12345678",
               up_wr_req, rsp_valid, up_wr_din);
    else passes++;
    up_wr_ack = 1'b1;
    @(negedge clk);
    up_wr_ack = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0)
      $display("[TB] FAIL wr_rsp: got valid/err=%b rdata=%h expected 10/00000000",
               {rsp_valid, rsp_err}, rsp_rdata);
    else passes++;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010)
      $display("[TB] FAIL wr_idle: got %b expected 010", {rsp_valid, cmd_ready, busy});
    else passes++;
  endtask

  task automatic test_read();
    rsp_ready = 1'b1;
    issueCmd(1'b0, 8'h01, 32'hFFFFFFFF);
    checks++;
    if ({up_rd_req, up_wr_req} !== 2'b10 || up_rd_addr !== 8'h01)
      $display("[TB] FAIL rd_req_cycle: got req=%b addr=%h expected 10/01", {up_rd_req, up_wr_req}, up_rd_addr);
    else passes++;
    @(negedge clk);
    up_rd_ack  = 1'b1;
    up_rd_dout = 32'h0000ABCD;
    @(negedge clk);
    up_rd_ack  = 1'b0;
    up_rd_dout = 32'h0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0000ABCD)
      $display("[TB] FAIL rd_rsp: got valid/err=%b rdata=%h expected 10/0000abcd", {rsp_valid, rsp_err}, rsp_rdata);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issueCmd(1'b0, 8'h22, 32'h0);
    @(negedge clk);
    up_rd_ack  = 1'b1;
    up_rd_dout = 32'hCAFEF00D;
    @(negedge clk);
    up_rd_ack  = 1'b0;
    up_rd_dout = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, cmd_ready, busy} !== 3'b101 || rsp_rdata !== 32'hCAFEF00D)
        $display("[TB] FAIL bp_hold[%0d]: got %b rdata=%h expected 101/cafef00d",
                 i, {rsp_valid, cmd_ready, busy}, rsp_rdata);
      else passes++;
      up_rd_ack  = (i == 1);
      up_rd_dout = (i == 1) ? 32'h0BAD0BAD : 32'h0;
      @(negedge clk);
    end
    up_rd_ack = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010)
      $display("[TB] FAIL bp_release: got %b expected 010", {rsp_valid, cmd_ready, busy});
    else passes++;
  endtask

  task automatic test_wrong_ack();
    rsp_ready = 1'b1;
    issueCmd(1'b0, 8'h30, 32'h0);
    @(negedge clk);
    up_wr_ack  = 1'b1;
    up_rd_dout = 32'h11111111;
    @(negedge clk);
    up_wr_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1)
        $display("[TB] FAIL wrong_ack_ignored[%0d]: got valid=%b busy=%b expected 0/1", i, rsp_valid, busy);
      else passes++;
      if (i < 2) @(negedge clk);
    end
    up_rd_ack  = 1'b1;
    up_rd_dout = 32'h5A5A1234;
    @(negedge clk);
    up_rd_ack  = 1'b0;
    up_rd_dout = 32'h22222222;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h5A5A1234)
      $display("[TB] FAIL wrong_ack_rsp: got %b rdata=%h expected 10/5a5a1234", {rsp_valid, rsp_err}, rsp_rdata);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int k;
    rsp_ready = 1'b1;
`ifdef UP_MASTER_TIMEOUT_EN
    issueCmd(1'b0, 8'h40, 32'h0);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== TO + 1)
      $display("[TB] FAIL timeout_latency: got %0d expected %0d", k, TO + 1);
    else passes++;
    checks++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
      $display("[TB] FAIL timeout_rsp: got err=%b rdata=%h expected 1/deadbeef", rsp_err, rsp_rdata);
    else passes++;
    @(negedge clk);
    up_rd_ack  = 1'b1;
    up_rd_dout = 32'h77777777;
    @(negedge clk);
    up_rd_ack = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010 || rsp_rdata !== 32'hDEADBEEF)
      $display("[TB] FAIL timeout_late_ack: got %b rdata=%h expected 010/deadbeef",
               {rsp_valid, cmd_ready, busy}, rsp_rdata);
    else passes++;
    issueCmd(1'b0, 8'h41, 32'h0);
    repeat (TO) @(negedge clk);
    up_rd_ack  = 1'b1;
    up_rd_dout = 32'h600D600D;
    @(negedge clk);
    up_rd_ack = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h600D600D)
      $display("[TB] FAIL timeout_ack_wins: got %b rdata=%h expected 10/600d600d", {rsp_valid, rsp_err}, rsp_rdata);
    else passes++;
    @(negedge clk);
`else
    k = 0;
    issueCmd(1'b0, 8'h40, 32'h0);
    while (k < 1000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if ({rsp_valid, cmd_ready, busy, rsp_err} !== 4'b0010)
      $display("[TB] FAIL no_timeout_wait: got %b expected 0010", {rsp_valid, cmd_ready, busy, rsp_err});
    else passes++;
    up_rd_ack  = 1'b1;
    up_rd_dout = 32'h13579BDF;
    @(negedge clk);
    up_rd_ack = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h13579BDF)
      $display("[TB] FAIL no_timeout_rsp: got %b rdata=%h expected 10/13579bdf", {rsp_valid, rsp_err}, rsp_rdata);
    else passes++;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    issueCmd(1'b1, 8'h55, 32'hA5A5A5A5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_valid, rsp_err, up_wr_req, up_rd_req} !== 6'b100000)
      $display("[TB] FAIL mid_reset_ctrl: got %b expected 100000",
               {cmd_ready, busy, rsp_valid, rsp_err, up_wr_req, up_rd_req});
    else passes++;
    checks++;
    if ({rsp_rdata, up_wr_din, up_wr_addr, up_rd_addr} !== '0)
      $display("[TB] FAIL mid_reset_data: got %h expected 0", {rsp_rdata, up_wr_din, up_wr_addr, up_rd_addr});
    else passes++;
    rst       = 1'b0;
    up_wr_ack = 1'b1;
    @(negedge clk);
    up_wr_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010)
      $display("[TB] FAIL mid_reset_late_ack: got %b expected 010", {rsp_valid, cmd_ready, busy});
    else passes++;
    issueCmd(1'b0, 8'h09, 32'h0);
    checks++;
    if (up_rd_req !== 1'b1 || up_rd_addr !== 8'h09)
      $display("[TB] FAIL post_reset_req: got req=%b addr=%h expected 1/09", up_rd_req, up_rd_addr);
    else passes++;
    @(negedge clk);
    up_rd_ack  = 1'b1;
    up_rd_dout = 32'h00000099;
    @(negedge clk);
    up_rd_ack  = 1'b0;
    up_rd_dout = 32'h0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h00000099)
      $display("[TB] FAIL post_reset_rsp: got %b rdata=%h expected 10/00000099", {rsp_valid, rsp_err}, rsp_rdata);
    else passes++;
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_wr     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b1;
    up_wr_ack  = 1'b0;
    up_rd_ack  = 1'b0;
    up_rd_dout = '0;

    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_wrong_ack();
    test_timeout();
    test_reset_mid();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
